// File: rtl/sr_muldiv_seq.sv
// sr_muldiv_seq: multicycle sequencer for the sr_cpu `mul` and `hypo` custom
// instructions. One radix-2 shift-add multiplier is shared by both ops; hypo
// squares each half-width operand, adds them, then extracts a bit-serial
// integer square root.
//
// Ports:
//   clk     CPU clock
//   rst     synchronous active-high reset
//   start   decoded mul/hypo, held by the CPU until valid
//   op      0 = mul (low WIDTH bits of srcA*srcB), 1 = hypo floor(sqrt(a^2+b^2))
//   srcA    rs1 value, sampled with start in IDLE
//   srcB    rs2 value, sampled with start in IDLE
//   stall   start & ~valid, holds the pc and register-file write
//   busy    high while iterating (MUL_A, MUL_B, SQRT)
//   valid   one-cycle pulse, result valid in this cycle
//   result  registered result, held until the next completion
module sr_muldiv_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned HW      = WIDTH / 2,
  parameter int unsigned SQ_ITER = WIDTH / 2 + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             stall,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW   = $clog2(WIDTH);
  localparam int unsigned RADW = 2 * SQ_ITER;   // radicand padded to whole bit pairs
  localparam int unsigned RW   = SQ_ITER + 3;   // partial remainder width

  typedef enum logic [2:0] {IDLE, MUL_A, MUL_B, SQRT, DONE} state_t;

  state_t            state, stateNext;
  logic              opR;
  logic [WIDTH-1:0]  mcand, mplier, acc, sq;
  logic [HW-1:0]     bHalf;
  logic [CW-1:0]     cnt;
  logic [RADW-1:0]   radSh;
  logic [RW-1:0]     rem;
  logic [SQ_ITER-1:0] root;

  logic [WIDTH-1:0]  accNext, aExt, bExt;
  logic [WIDTH:0]    radSum;
  logic [RW-1:0]     remSh, trial, remNext;
  logic              remGe;
  logic [SQ_ITER-1:0] rootNext;
  logic              cntZero;

  assign cntZero = (cnt == '0);
  assign aExt    = WIDTH'(srcA[HW-1:0]);
  assign bExt    = WIDTH'(bHalf);
  assign accNext = acc + (mplier[0] ? mcand : '0);
  assign radSum  = {1'b0, sq} + {1'b0, accNext};

  // Restoring root: bring down the next two radicand bits and try appending a
  // 1 to the root. Comparing rem against (root<<2)|1 is the incremental form
  // of (root|bit)^2 <= rad, so no multiplier is needed.
  assign remSh    = (rem << 2) | RW'(radSh[RADW-1 -: 2]);
  assign trial    = RW'({root, 2'b01});
  assign remGe    = (remSh >= trial);
  assign remNext  = remGe ? (remSh - trial) : remSh;
  assign rootNext = {root[SQ_ITER-2:0], remGe};

  assign stall = start & ~valid;

  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    valid     = 1'b0;
    unique case (state)
      IDLE:  if (start) stateNext = MUL_A;
      MUL_A: begin
        busy = 1'b1;
        if (cntZero) stateNext = opR ? MUL_B : DONE;
      end
      MUL_B: begin
        busy = 1'b1;
        if (cntZero) stateNext = SQRT;
      end
      SQRT: begin
        busy = 1'b1;
        if (cntZero) stateNext = DONE;
      end
      DONE: begin
        valid     = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      opR    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      sq     <= '0;
      bHalf  <= '0;
      cnt    <= '0;
      radSh  <= '0;
      rem    <= '0;
      root   <= '0;
      result <= '0;
    end else begin
      state <= stateNext;
      unique case (state)
        IDLE: begin
          if (start) begin
            opR    <= op;
            bHalf  <= srcB[HW-1:0];
            mcand  <= op ? aExt : srcA;
            mplier <= op ? aExt : srcB;
            acc    <= '0;
            cnt    <= CW'(WIDTH - 1);
          end
        end
        MUL_A: begin
          acc    <= accNext;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cntZero) begin
            if (opR) begin
              // first square done; restart the multiplier on b
              sq     <= accNext;
              mcand  <= bExt;
              mplier <= bExt;
              acc    <= '0;
              cnt    <= CW'(WIDTH - 1);
            end else begin
              result <= accNext;
            end
          end
        end
        MUL_B: begin
          acc    <= accNext;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cntZero) begin
            radSh <= RADW'(radSum);
            rem   <= '0;
            root  <= '0;
            cnt   <= CW'(SQ_ITER - 1);
          end
        end
        SQRT: begin
          rem   <= remNext;
          root  <= rootNext;
          radSh <= radSh << 2;
          cnt   <= cnt - 1'b1;
          if (cntZero) result <= WIDTH'(rootNext);
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_muldiv_seq.sv
module tb_sr_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        opI;
  logic [31:0] srcA, srcB;
  logic        stall, busy, valid;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [31:0] expQ[$];

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[11];

  sr_muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(opI), .srcA(srcA), .srcB(srcB),
    .stall(stall), .busy(busy), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpectedValid: got valid with result 0x%0h, want no pulse", result);
      end else begin
        check("result", result, expQ.pop_front());
      end
    end
  end

  // Drives a request at a negedge and waits for valid; lat counts negedges
  // from the drive point to the valid cycle.
  task automatic doOp(input logic o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat, input bit chkBusy);
    int  n = 0;
    bit  busyBad = 0;
    bit  stallBad = 0;
    start = 1'b1;
    opI   = o;
    srcA  = a;
    srcB  = b;
    expQ.push_back(exp);
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        n = i;
        break;
      end
      if (stall !== 1'b1) stallBad = 1;
      if (chkBusy && busy !== 1'b1) busyBad = 1;
      if (i == lat - 30) begin
        opI  = $urandom_range(0, 1);
        srcA = $urandom;
        srcB = $urandom;
      end
    end
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no valid in 300 cycles, want valid after %0d", lat);
    end else begin
      check("latency", n, lat);
      check("stallAtValid", {31'b0, stall}, 32'd0);
      check("busyAtValid", {31'b0, busy}, 32'd0);
      check("stallWindow", {31'b0, stallBad}, 32'd0);
      if (chkBusy) check("busyWindow", {31'b0, busyBad}, 32'd0);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 32'd7,         32'd6,         32'd42};
    tbl[1]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001};
    tbl[2]  = '{1'b0, 32'h00010000,  32'h00010000,  32'h00000000};
    tbl[3]  = '{1'b0, 32'h12345678,  32'd9,         32'hA3D70A38};
    tbl[4]  = '{1'b1, 32'd3,         32'd4,         32'd5};
    tbl[5]  = '{1'b1, 32'd0,         32'd0,         32'd0};
    tbl[6]  = '{1'b1, 32'h0000FFFF,  32'h0000FFFF,  32'd92680};
    tbl[7]  = '{1'b1, 32'h12340003,  32'h56780004,  32'd5};
    tbl[8]  = '{1'b1, 32'd5,         32'd12,        32'd13};
    tbl[9]  = '{1'b1, 32'd1,         32'd1,         32'd1};
    tbl[10] = '{1'b1, 32'h0000FFFF,  32'd0,         32'd65535};

    rst = 1'b1; start = 1'b0; opI = 1'b0; srcA = '0; srcB = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rstBusy",   {31'b0, busy},  32'd0);
    check("rstValid",  {31'b0, valid}, 32'd0);
    check("rstStall",  {31'b0, stall}, 32'd0);
    check("rstResult", result,         32'd0);

    foreach (tbl[i]) begin
      doOp(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].op ? 82 : 33, 1'b1);
      start = 1'b0;
      @(negedge clk);
      check("resultHold", result, tbl[i].exp);
    end

    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b, p;
      a = $urandom;
      b = $urandom;
      p = a * b;
      doOp(1'b0, a, b, p, 33, 1'b1);
      start = 1'b0;
      @(negedge clk);
    end

    // Abort a mul with reset while start stays high, then rerun it cleanly.
    start = 1'b1; opI = 1'b0; srcA = 32'd9; srcB = 32'd11;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abortBusy",  {31'b0, busy},  32'd0);
    check("abortValid", {31'b0, valid}, 32'd0);
    rst = 1'b0;
    doOp(1'b0, 32'd9, 32'd11, 32'd99, 33, 1'b1);
    start = 1'b0;
    @(negedge clk);

    // Back-to-back: start held across DONE; the next request starts in IDLE.
    doOp(1'b0, 32'd5, 32'd5, 32'd25, 33, 1'b1);
    doOp(1'b1, 32'd6, 32'd8, 32'd10, 83, 1'b0);
    start = 1'b0;

    repeat (5) @(negedge clk);
    check("queueEmpty", expQ.size(), 32'd0);
    check("finalResult", result, 32'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
